edge_mask_apply: RTL and testbench

//  Stage directly downstream of the grayscale mask writer.

---
 rtl/edge_mask_apply_pkg.sv | 41 ++++
 rtl/edge_mask_apply_mask_coord_gen.sv | 78 +++++++
 rtl/edge_mask_apply.sv | 144 ++++++++++++++
 tb/tb_edge_mask_apply.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_mask_apply_pkg.sv
// ============================================================================
// Module      : edge_mask_apply_pkg
// Description : Frame and mask-rectangle geometry plus FSM state encoding
//               shared by the edge-mask crop/gate stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package edge_mask_apply_pkg;

  localparam int WIDTH      = 8;
  localparam int HEIGHT     = 6;
  localparam int STARTING_X = 2;
  localparam int ENDING_X   = 5;
  localparam int STARTING_Y = 1;
  localparam int ENDING_Y   = 3;

  localparam int REDUCED_WIDTH      = ENDING_X - STARTING_X + 1;
  localparam int REDUCED_HEIGHT     = ENDING_Y - STARTING_Y + 1;
  localparam int REDUCED_IMAGE_SIZE = REDUCED_WIDTH * REDUCED_HEIGHT;

  localparam int ADDR_W = $clog2(REDUCED_IMAGE_SIZE);
  localparam int KEPT_W = $clog2(REDUCED_IMAGE_SIZE + 1);
  localparam int X_W    = $clog2(WIDTH);
  localparam int Y_W    = $clog2(HEIGHT);
  localparam int XM_W   = $clog2(REDUCED_WIDTH);
  localparam int YM_W   = $clog2(REDUCED_HEIGHT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_mask_apply_mask_coord_gen.sv
// ============================================================================
// Module      : mask_coord_gen
// Description : Full-frame and mask-rectangle raster counters; flags pixels
//               inside the rectangle and forms their mask BRAM address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mask_coord_gen
  import edge_mask_apply_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic              in_rect,
  output logic              last_pixel,
  output logic [ADDR_W-1:0] addr
);

  logic [X_W-1:0]  x_q,  x_d;
  logic [Y_W-1:0]  y_q,  y_d;
  logic [XM_W-1:0] xm_q, xm_d;
  logic [YM_W-1:0] ym_q, ym_d;

  always_comb begin
    in_rect    = in_range(int'(x_q), STARTING_X, ENDING_X) &&
                 in_range(int'(y_q), STARTING_Y, ENDING_Y);
    last_pixel = (x_q == X_W'(WIDTH - 1)) && (y_q == Y_W'(HEIGHT - 1));
    addr       = ADDR_W'(int'(ym_q) * REDUCED_WIDTH + int'(xm_q));
  end

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    xm_d = xm_q;
    ym_d = ym_q;
    if (clear) begin
      x_d  = '0;
      y_d  = '0;
      xm_d = '0;
      ym_d = '0;
    end else if (advance) begin
      if (x_q == X_W'(WIDTH - 1)) begin
        x_d = '0;
        y_d = (y_q == Y_W'(HEIGHT - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      // Mask counters only move for pixels that land inside the rectangle
      if (in_rect) begin
        if (xm_q == XM_W'(REDUCED_WIDTH - 1)) begin
          xm_d = '0;
          ym_d = (ym_q == YM_W'(REDUCED_HEIGHT - 1)) ? '0 : ym_q + 1'b1;
        end else begin
          xm_d = xm_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      xm_q <= '0;
      ym_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      xm_q <= xm_d;
      ym_q <= ym_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_mask_apply.sv
// ============================================================================
// Module      : edge_mask_apply
// Description : Crops a streamed edge frame to the mask rectangle and gates
//               each pixel with its mask byte before pushing it to the Hough
//               FIFO. Optional kept-pixel counter under EDGE_MASK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_mask_apply
  import edge_mask_apply_pkg::*;
#(
  parameter logic [7:0] MASK_THRESHOLD = 8'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mask_ready,
  input  logic              hough_done,
  output logic              in_rd_en,
  input  logic              in_empty,
  input  logic [7:0]        in_dout,
  output logic [ADDR_W-1:0] mask_rd_addr,
  input  logic [7:0]        mask_rd_data,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic [7:0]        out_din
`ifdef EDGE_MASK_STATS_EN
  ,
  output logic [KEPT_W-1:0] kept_count
`endif
);

  state_t            state_q, state_d;
  logic              done_pend_q, done_pend_d;
  logic              s1_valid_q, s1_valid_d;
  logic [7:0]        s1_pix_q, s1_pix_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

  logic              pop;
  logic              load;
  logic              coord_clear;
  logic              in_rect;
  logic              last_pixel;
  logic [ADDR_W-1:0] pix_addr;

  mask_coord_gen u_coord (
    .clock      (clock),
    .reset      (reset),
    .clear      (coord_clear),
    .advance    (pop),
    .in_rect    (in_rect),
    .last_pixel (last_pixel),
    .addr       (pix_addr)
  );

  // A full output FIFO only blocks a pop when S1 cannot drain this cycle
  always_comb begin
    pop          = (state_q == RUN) && !in_empty && (!s1_valid_q || !out_full);
    load         = pop && in_rect;
    in_rd_en     = pop;
    out_wr_en    = s1_valid_q && !out_full;
    out_din      = (s1_valid_q && (mask_rd_data > MASK_THRESHOLD)) ? s1_pix_q : 8'h00;
    mask_rd_addr = load ? pix_addr : s1_addr_q;
  end

  always_comb begin
    state_d     = state_q;
    done_pend_d = done_pend_q;
    coord_clear = 1'b0;
    case (state_q)
      IDLE: begin
        coord_clear = 1'b1;
        done_pend_d = 1'b0;
        if (mask_ready && !in_empty) state_d = RUN;
      end
      RUN: begin
        if (pop && last_pixel) state_d = DONE;
      end
      DONE: begin
        // An early hough_done is remembered until S1 has drained
        if ((hough_done || done_pend_q) && !s1_valid_q) begin
          state_d     = IDLE;
          done_pend_d = 1'b0;
        end else if (hough_done) begin
          done_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pix_d   = s1_pix_q;
    s1_addr_d  = s1_addr_q;
    if (load) begin
      s1_valid_d = 1'b1;
      s1_pix_d   = in_dout;
      s1_addr_d  = pix_addr;
    end else if (out_wr_en) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      done_pend_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
      s1_valid_q  <= s1_valid_d;
      s1_pix_q    <= s1_pix_d;
      s1_addr_q   <= s1_addr_d;
    end
  end

`ifdef EDGE_MASK_STATS_EN
  logic [KEPT_W-1:0] kept_q, kept_d;

  always_comb begin
    kept_d = kept_q;
    if ((state_q == IDLE) && (state_d == RUN)) begin
      kept_d = '0;
    end else if (out_wr_en && (out_din != 8'h00) &&
                 (kept_q != KEPT_W'(REDUCED_IMAGE_SIZE))) begin
      kept_d = kept_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) kept_q <= '0;
    else       kept_q <= kept_d;
  end

  assign kept_count = kept_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_edge_mask_apply.sv
// ============================================================================
// Module      : tb_edge_mask_apply
// Description : Directed self-checking bench for edge_mask_apply with edge
//               FIFO, mask BRAM and output FIFO models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_mask_apply;
  import edge_mask_apply_pkg::*;

  localparam int FRAME = WIDTH * HEIGHT;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              mask_ready = 1'b0;
  logic              hough_done = 1'b0;
  logic              in_rd_en;
  logic              in_empty;
  logic [7:0]        in_dout;
  logic [ADDR_W-1:0] mask_rd_addr;
  logic [7:0]        mask_rd_data = 8'h00;
  logic              out_wr_en;
  logic              out_full = 1'b0;
  logic [7:0]        out_din;
`ifdef EDGE_MASK_STATS_EN
  logic [KEPT_W-1:0] kept_count;
`endif

  edge_mask_apply dut (
    .clock        (clock),
    .reset        (reset),
    .mask_ready   (mask_ready),
    .hough_done   (hough_done),
    .in_rd_en     (in_rd_en),
    .in_empty     (in_empty),
    .in_dout      (in_dout),
    .mask_rd_addr (mask_rd_addr),
    .mask_rd_data (mask_rd_data),
    .out_wr_en    (out_wr_en),
    .out_full     (out_full),
    .out_din      (out_din)
`ifdef EDGE_MASK_STATS_EN
    ,
    .kept_count   (kept_count)
`endif
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pix_mode = 0;
  int   mask_mode = 0;
  int   rd_ptr = 0;
  int   avail = 0;
  int   pops = 0;
  int   out_n = 0;
  int   bad_pop = 0;
  int   bad_wr = 0;
  logic fifo_clr = 1'b0;
  logic log_clr = 1'b0;
  logic toggle_en = 1'b0;
  logic gap = 1'b0;
  logic [7:0] log_q [0:63];
  int   wcyc [0:63];
  int   pcyc [0:FRAME-1];

  // Crop of the ramp frame (value = y*8+x) to x=2..5, y=1..3
  logic [7:0] exp_ramp [0:11] = '{8'd10, 8'd11, 8'd12, 8'd13,
                                  8'd18, 8'd19, 8'd20, 8'd21,
                                  8'd26, 8'd27, 8'd28, 8'd29};

  assign in_empty = (rd_ptr >= avail) || gap;
  assign in_dout  = (pix_mode == 0) ? rd_ptr[7:0] : 8'h80;

  always @(posedge clock) begin
    cyc          <= cyc + 1;
    mask_rd_data <= (mask_mode == 0 || mask_rd_addr[0]) ? 8'hFF : 8'h00;
    if (fifo_clr) begin
      rd_ptr <= 0;
      pops   <= 0;
    end else if (in_rd_en) begin
      if (in_empty) bad_pop <= bad_pop + 1;
      if (rd_ptr < FRAME) pcyc[rd_ptr] <= cyc;
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
    if (log_clr) begin
      out_n <= 0;
    end else if (out_wr_en) begin
      if (out_full) bad_wr <= bad_wr + 1;
      if (out_n < 64) begin
        log_q[out_n] <= out_din;
        wcyc[out_n]  <= cyc;
      end
      out_n <= out_n + 1;
    end
  end

  always @(negedge clock) gap <= toggle_en ? ~gap : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input int pm, input int mm);
    avail     = 0;
    pix_mode  = pm;
    mask_mode = mm;
    fifo_clr  = 1'b1;
    log_clr   = 1'b1;
    @(negedge clock);
    fifo_clr  = 1'b0;
    log_clr   = 1'b0;
    avail     = FRAME;
  endtask

  task automatic wait_frame(input string tag);
    for (int i = 0; i < 400 && pops < FRAME; i++) @(negedge clock);
    check({tag, "_pops"}, pops, FRAME);
    repeat (4) @(negedge clock);
  endtask

  task automatic pulse_hough();
    @(negedge clock);
    hough_done = 1'b1;
    @(negedge clock);
    hough_done = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_ramp(input string tag);
    check({tag, "_count"}, out_n, 12);
    for (int i = 0; i < 12; i++) check({tag, "_pix"}, log_q[i], exp_ramp[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, in_rd_en, 0);
    check({tag, "_wr_en"}, out_wr_en, 0);
    check({tag, "_din"}, out_din, 0);
    check({tag, "_addr"}, mask_rd_addr, 0);
`ifdef EDGE_MASK_STATS_EN
    check({tag, "_kept"}, kept_count, 0);
`endif
  endtask

  initial begin
    logic [ADDR_W-1:0] a0;
    logic [7:0]        d0;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // mask not ready: frame available but nothing may be popped
    start_frame(0, 0);
    repeat (10) @(negedge clock);
    check("idle_no_pop", pops, 0);
    check("idle_no_wr", out_n, 0);
    mask_ready = 1'b1;
    wait_frame("f1");
    check_ramp("f1");
    check("f1_latency", wcyc[0] - pcyc[10], 1);
    for (int r = 0; r < 3; r++)
      for (int c = 1; c < 4; c++)
        check("f1_b2b", wcyc[r*4+c] - wcyc[r*4+c-1], 1);
`ifdef EDGE_MASK_STATS_EN
    check("f1_kept", kept_count, 12);
`endif

    // second frame queued while in DONE must wait for hough_done
    avail    = 0;
    fifo_clr = 1'b1;
    log_clr  = 1'b1;
    @(negedge clock);
    fifo_clr = 1'b0;
    log_clr  = 1'b0;
    avail    = FRAME;
    repeat (5) @(negedge clock);
    check("done_hold", pops, 0);
    pulse_hough();
    wait_frame("f2");
    check_ramp("f2");
    pulse_hough();

    // checkerboard mask, constant edges
    start_frame(1, 1);
    wait_frame("chk");
    check("chk_count", out_n, 12);
    for (int i = 0; i < 12; i++)
      check("chk_pix", log_q[i], (i % 2 == 1) ? 8'h80 : 8'h00);
`ifdef EDGE_MASK_STATS_EN
    check("chk_kept", kept_count, 6);
`endif
    pulse_hough();

    // output FIFO full for 5 cycles mid-row
    start_frame(0, 0);
    for (int i = 0; i < 200 && out_n < 5; i++) @(negedge clock);
    check("stall_reach", out_n, 5);
    out_full = 1'b1;
    #1;
    a0 = mask_rd_addr;
    d0 = out_din;
    check("stall_addr0", a0, 5);
    check("stall_din0", d0, 19);
    check("stall_rd0", in_rd_en, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("stall_rd", in_rd_en, 0);
      check("stall_addr", mask_rd_addr, a0);
      check("stall_din", out_din, d0);
    end
    out_full = 1'b0;
    wait_frame("stall");
    check_ramp("stall");
    pulse_hough();

    // edge FIFO empty every other cycle
    toggle_en = 1'b1;
    start_frame(0, 0);
    wait_frame("gap");
    toggle_en = 1'b0;
    check_ramp("gap");
    pulse_hough();

    // reset mid-row, then a fresh frame
    start_frame(0, 0);
    for (int i = 0; i < 200 && out_n < 6; i++) @(negedge clock);
    check("rst_reach", out_n, 6);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midrst");
    avail = 0;
    reset = 1'b0;
    start_frame(0, 0);
    wait_frame("post");
    check_ramp("post");
`ifdef EDGE_MASK_STATS_EN
    check("post_kept", kept_count, 12);
`endif
    pulse_hough();

    check("underflow", bad_pop, 0);
    check("overflow", bad_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
